// File: rtl/bcm_scan_scheduler.sv
// Binary-coded-modulation scan scheduler for a HUB75 panel: sequences shift, blank,
// latch and bit-weighted OE windows, overlapping the next shift with the current window.
module bcm_scan_scheduler #(
  parameter int PIXEL_HALFHEIGHT  = 16,
  parameter int BRIGHTNESS_LEVELS = 6,
  parameter int BASE_TIMEOUT      = 10,
  parameter int BLANK_TICKS       = 2
) (
  input  logic                                 clk_in,
  input  logic                                 reset,
  input  logic                                 enable,
  output logic                                 shift_start,
  output logic [$clog2(PIXEL_HALFHEIGHT)-1:0]  shift_row,
  output logic [$clog2(BRIGHTNESS_LEVELS)-1:0] shift_bit,
  input  logic                                 shift_done,
  output logic                                 latch,
  output logic                                 oe_n,
  output logic [$clog2(PIXEL_HALFHEIGHT)-1:0]  row_addr,
  output logic [$clog2(BRIGHTNESS_LEVELS)-1:0] cur_bit,
  output logic                                 frame_done
);
  // state      | meaning
  // IDLE       | panel dark, waiting for enable
  // WAIT_SHIFT | panel dark, shift of the next step still outstanding
  // BLANK      | OE high settle time before the latch
  // LATCH      | LAT pulse, displayed row/bit take the shifted step
  // DISPLAY    | OE low for the bit-weighted on-time, next shift overlaps
  // DRAIN      | scanning stopped, waiting out the last requested shift
  typedef enum logic [2:0] {IDLE, WAIT_SHIFT, BLANK, LATCH, DISPLAY, DRAIN} state_t;

  localparam int RW = $clog2(PIXEL_HALFHEIGHT);
  localparam int BW = $clog2(BRIGHTNESS_LEVELS);
  localparam int CW = $clog2((BASE_TIMEOUT << (BRIGHTNESS_LEVELS - 1)) + 1);
  localparam int KW = $clog2(BLANK_TICKS + 1);

  localparam logic [RW-1:0] LAST_ROW   = RW'(PIXEL_HALFHEIGHT - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(BRIGHTNESS_LEVELS - 1);
  localparam logic [CW-1:0] BASE_CNT   = CW'(BASE_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [KW-1:0] BLANK_LOAD = KW'(BLANK_TICKS - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [KW-1:0]   bcnt, bcnt_nxt;
  logic            pending, pending_nxt;
  logic            done_seen, seen_nxt;
  logic [RW-1:0]   srow_nxt, row_nxt;
  logic [BW-1:0]   sbit_nxt, bit_nxt;
  logic            start_nxt, latch_nxt, oe_n_nxt, frame_nxt;
  logic            done_accept, got_done, bit_wrap;
  logic [RW-1:0]   adv_row;
  logic [BW-1:0]   adv_bit;
  logic [CW-1:0]   disp_load;

  // a done in the same cycle as its start cannot belong to that request
  assign done_accept = shift_done & pending & ~shift_start;
  assign got_done    = done_seen | done_accept;
  assign disp_load   = BASE_CNT << shift_bit;
  assign bit_wrap    = (shift_bit == LAST_BIT);
  assign adv_bit     = bit_wrap ? '0 : shift_bit + BW'(1);
  assign adv_row     = !bit_wrap ? shift_row :
                       (shift_row == LAST_ROW) ? '0 : shift_row + RW'(1);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bcnt_nxt    = bcnt;
    srow_nxt    = shift_row;
    sbit_nxt    = shift_bit;
    row_nxt     = row_addr;
    bit_nxt     = cur_bit;
    start_nxt   = 1'b0;
    pending_nxt = pending;
    seen_nxt    = done_seen;
    if (done_accept) begin
      pending_nxt = 1'b0;
      seen_nxt    = 1'b1;
    end
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt   = WAIT_SHIFT;
          start_nxt   = 1'b1;
          srow_nxt    = '0;
          sbit_nxt    = '0;
          pending_nxt = 1'b1;
          seen_nxt    = 1'b0;
        end
      end
      WAIT_SHIFT: begin
        if (got_done) begin
          state_nxt = BLANK;
          bcnt_nxt  = BLANK_LOAD;
        end
      end
      BLANK: begin
        if (bcnt == '0) state_nxt = LATCH;
        else            bcnt_nxt  = bcnt - KW'(1);
      end
      LATCH: begin
        state_nxt   = DISPLAY;
        row_nxt     = shift_row;
        bit_nxt     = shift_bit;
        cnt_nxt     = disp_load;
        start_nxt   = 1'b1;
        srow_nxt    = adv_row;
        sbit_nxt    = adv_bit;
        pending_nxt = 1'b1;
        seen_nxt    = 1'b0;
      end
      DISPLAY: begin
        if (cnt == CNT_ONE) begin
          if (!enable) begin
            state_nxt = DRAIN;
          end else if (got_done) begin
            state_nxt = BLANK;
            bcnt_nxt  = BLANK_LOAD;
          end else begin
            state_nxt = WAIT_SHIFT;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      DRAIN: begin
        if (got_done) begin
          state_nxt = IDLE;
          srow_nxt  = '0;
          sbit_nxt  = '0;
          seen_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    latch_nxt = (state_nxt == LATCH);
    oe_n_nxt  = (state_nxt != DISPLAY);
    frame_nxt = (state_nxt == DISPLAY) && (cnt_nxt == CNT_ONE) &&
                (bit_nxt == LAST_BIT) && (row_nxt == LAST_ROW);
  end

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt         <= '0;
      bcnt        <= '0;
      pending     <= 1'b0;
      done_seen   <= 1'b0;
      shift_row   <= '0;
      shift_bit   <= '0;
      row_addr    <= '0;
      cur_bit     <= '0;
      shift_start <= 1'b0;
      latch       <= 1'b0;
      oe_n        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      bcnt        <= bcnt_nxt;
      pending     <= pending_nxt;
      done_seen   <= seen_nxt;
      shift_row   <= srow_nxt;
      shift_bit   <= sbit_nxt;
      row_addr    <= row_nxt;
      cur_bit     <= bit_nxt;
      shift_start <= start_nxt;
      latch       <= latch_nxt;
      oe_n        <= oe_n_nxt;
      frame_done  <= frame_nxt;
    end
  end
endmodule

// File: tb/tb_bcm_scan_scheduler.sv
// Bench for bcm_scan_scheduler: default-size instance plus a 2x2 instance for wrap and frame_done.
module tb_bcm_scan_scheduler;
  localparam int H = 16, L = 6, BASE = 10, BLANK = 2;
  localparam int HS = 2, LS = 2, BASES = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, shift_done = 1'b0;
  logic shift_start, latch, oe_n, frame_done;
  logic [3:0] shift_row, row_addr;
  logic [2:0] shift_bit, cur_bit;
  logic enable_s = 1'b0, shift_done_s = 1'b0;
  logic shift_start_s, latch_s, oe_n_s, frame_done_s;
  logic [0:0] shift_row_s, row_addr_s, shift_bit_s, cur_bit_s;

  int cyc = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcm_scan_scheduler dut (
    .clk_in(clk), .reset(reset), .enable(enable), .shift_start(shift_start),
    .shift_row(shift_row), .shift_bit(shift_bit), .shift_done(shift_done),
    .latch(latch), .oe_n(oe_n), .row_addr(row_addr), .cur_bit(cur_bit),
    .frame_done(frame_done));

  bcm_scan_scheduler #(.PIXEL_HALFHEIGHT(HS), .BRIGHTNESS_LEVELS(LS),
                       .BASE_TIMEOUT(BASES), .BLANK_TICKS(BLANK)) dut_s (
    .clk_in(clk), .reset(reset), .enable(enable_s), .shift_start(shift_start_s),
    .shift_row(shift_row_s), .shift_bit(shift_bit_s), .shift_done(shift_done_s),
    .latch(latch_s), .oe_n(oe_n_s), .row_addr(row_addr_s), .cur_bit(cur_bit_s),
    .frame_done(frame_done_s));

  // reference: step k displays row (k/L)%H, bitplane k%L, for BASE<<bit cycles
  function automatic int exp_row(int k, int h, int l); return (k / l) % h; endfunction
  function automatic int exp_bit(int k, int l); return k % l; endfunction

  typedef struct { int t0; int len; int row; int bitp; } run_t;
  typedef struct { int t; int row; int bitp; } start_t;
  run_t runs[$], runs_s[$];
  start_t starts[$];
  int lats[$], dones[$], fds[$], fds_s[$];
  int run_len = 0, run_t0 = 0, run_row = 0, run_bit = 0, overlap_err = 0;
  int rl_s = 0, rt_s = 0, rr_s = 0, rb_s = 0;

  // shifter models: answer shf_delay cycles after each start
  int cd = 0, cd_s = 0, shf_delay = 3;
  bit keep_inflight = 1'b0;
  always @(negedge clk) begin
    shift_done = 1'b0;
    if (reset === 1'b1 && !keep_inflight) cd = 0;
    else if (cd > 0) begin
      cd--;
      if (cd == 0) begin shift_done = 1'b1; dones.push_back(cyc); end
    end
    if (shift_start === 1'b1) cd = shf_delay;
  end
  always @(negedge clk) begin
    shift_done_s = 1'b0;
    if (reset === 1'b1) cd_s = 0;
    else if (cd_s > 0) begin
      cd_s--;
      if (cd_s == 0) shift_done_s = 1'b1;
    end
    if (shift_start_s === 1'b1) cd_s = 3;
  end

  always @(negedge clk) begin
    if (latch === 1'b1) begin
      lats.push_back(cyc);
      if (oe_n !== 1'b1) overlap_err++;
    end
    if (shift_start === 1'b1) starts.push_back('{cyc, int'(shift_row), int'(shift_bit)});
    if (frame_done === 1'b1) fds.push_back(cyc);
    if (oe_n === 1'b0) begin
      if (run_len == 0) begin run_t0 = cyc; run_row = int'(row_addr); run_bit = int'(cur_bit); end
      run_len++;
    end else if (run_len > 0) begin
      runs.push_back('{run_t0, run_len, run_row, run_bit});
      run_len = 0;
    end
  end
  always @(negedge clk) begin
    if (frame_done_s === 1'b1) fds_s.push_back(cyc);
    if (oe_n_s === 1'b0) begin
      if (rl_s == 0) begin rt_s = cyc; rr_s = int'(row_addr_s); rb_s = int'(cur_bit_s); end
      rl_s++;
    end else if (rl_s > 0) begin
      runs_s.push_back('{rt_s, rl_s, rr_s, rb_s});
      rl_s = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; enable_s = 1'b0; keep_inflight = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_runs(input int n, input int budget, output bit ok);
    int k = 0;
    while (runs.size() < n && k < budget) begin tick(); k++; end
    ok = (runs.size() >= n);
  endtask

  task automatic test_reset();
    int busy = 0;
    reset = 1'b1; enable = 1'b0;
    repeat (3) tick();
    n_chk++; if (oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n: got %b want 1", oe_n); end
    reset = 1'b0;
    tick();
    n_chk++; if (latch !== 1'b0) begin n_fail++; $display("FAIL reset_latch: got %b want 0", latch); end
    n_chk++; if (shift_start !== 1'b0) begin n_fail++; $display("FAIL reset_shift_start: got %b want 0", shift_start); end
    n_chk++; if (row_addr !== 4'd0) begin n_fail++; $display("FAIL reset_row_addr: got %0d want 0", row_addr); end
    n_chk++; if (cur_bit !== 3'd0) begin n_fail++; $display("FAIL reset_cur_bit: got %0d want 0", cur_bit); end
    n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_chk++; if (shift_row !== 4'd0 || shift_bit !== 3'd0) begin n_fail++; $display("FAIL reset_shift_idx: got %0d/%0d want 0/0", shift_row, shift_bit); end
    repeat (50) begin
      tick();
      if (oe_n !== 1'b1 || latch !== 1'b0 || shift_start !== 1'b0 || frame_done !== 1'b0) busy++;
    end
    n_chk++; if (busy != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles want 0", busy); end
  endtask

  task automatic test_bitplane_order();
    int br, bs, bl;
    bit ok;
    apply_reset();
    shf_delay = 3;
    br = runs.size(); bs = starts.size(); bl = lats.size();
    enable = 1'b1;
    wait_runs(br + L, 2000, ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL order_timeout: got %0d runs want %0d", runs.size() - br, L);
    end else begin
      n_chk++;
      if (lats[bl] - starts[bs].t != 3 + BLANK + 1) begin
        n_fail++; $display("FAIL first_latch_latency: got %0d want %0d", lats[bl] - starts[bs].t, 3 + BLANK + 1);
      end
      for (int k = 0; k < L; k++) begin
        n_chk++;
        if (runs[br+k].len != (BASE << exp_bit(k, L)) || runs[br+k].bitp != exp_bit(k, L) ||
            runs[br+k].row != exp_row(k, H, L)) begin
          n_fail++; $display("FAIL order_run%0d: got len %0d row %0d bit %0d want len %0d row %0d bit %0d", k,
            runs[br+k].len, runs[br+k].row, runs[br+k].bitp, BASE << exp_bit(k, L), exp_row(k, H, L), exp_bit(k, L));
        end
        n_chk++;
        if (starts[bs+k+1].t != runs[br+k].t0) begin
          n_fail++; $display("FAIL overlap_start%0d: got cycle %0d want %0d", k + 1, starts[bs+k+1].t, runs[br+k].t0);
        end
      end
      for (int k = 0; k <= L; k++) begin
        n_chk++;
        if (starts[bs+k].row != exp_row(k, H, L) || starts[bs+k].bitp != exp_bit(k, L)) begin
          n_fail++; $display("FAIL shift_req%0d: got %0d/%0d want %0d/%0d", k, starts[bs+k].row,
            starts[bs+k].bitp, exp_row(k, H, L), exp_bit(k, L));
        end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_slow_shifter();
    int br, bl, bd;
    bit ok;
    apply_reset();
    shf_delay = 400;
    br = runs.size(); bl = lats.size(); bd = dones.size();
    enable = 1'b1;
    wait_runs(br + 2, 2500, ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL slow_timeout: got %0d runs want 2", runs.size() - br);
    end else begin
      n_chk++; if (runs[br].len != BASE) begin n_fail++; $display("FAIL slow_bit0_len: got %0d want %0d", runs[br].len, BASE); end
      n_chk++;
      if (lats[bl+1] - dones[bd+1] != BLANK + 1) begin
        n_fail++; $display("FAIL slow_latch_after_done: got %0d want %0d", lats[bl+1] - dones[bd+1], BLANK + 1);
      end
      n_chk++;
      if (runs[br+1].t0 != lats[bl+1] + 1 || runs[br+1].len != BASE * 2 || runs[br+1].bitp != 1) begin
        n_fail++; $display("FAIL slow_second_run: got t0 %0d len %0d bit %0d want t0 %0d len %0d bit 1",
          runs[br+1].t0, runs[br+1].len, runs[br+1].bitp, lats[bl+1] + 1, BASE * 2);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_small_wrap();
    int b, bf, k, nfd;
    apply_reset();
    b = runs_s.size(); bf = fds_s.size();
    enable_s = 1'b1;
    k = 0;
    while (runs_s.size() < b + 5 && k < 600) begin tick(); k++; end
    n_chk++;
    if (runs_s.size() < b + 5) begin
      n_fail++; $display("FAIL small_timeout: got %0d runs want 5", runs_s.size() - b);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (runs_s[b+i].row != exp_row(i, HS, LS) || runs_s[b+i].bitp != exp_bit(i, LS) ||
            runs_s[b+i].len != (BASES << exp_bit(i, LS))) begin
          n_fail++; $display("FAIL small_step%0d: got row %0d bit %0d len %0d want row %0d bit %0d len %0d", i,
            runs_s[b+i].row, runs_s[b+i].bitp, runs_s[b+i].len, exp_row(i, HS, LS), exp_bit(i, LS), BASES << exp_bit(i, LS));
        end
      end
      nfd = 0;
      for (int j = bf; j < fds_s.size(); j++) if (fds_s[j] < runs_s[b+4].t0) nfd++;
      n_chk++; if (nfd != 1) begin n_fail++; $display("FAIL small_frame_done_count: got %0d want 1", nfd); end
      n_chk++;
      if (fds_s[bf] != runs_s[b+3].t0 + runs_s[b+3].len - 1) begin
        n_fail++; $display("FAIL small_frame_done_cycle: got %0d want %0d", fds_s[bf], runs_s[b+3].t0 + runs_s[b+3].len - 1);
      end
    end
    enable_s = 1'b0;
  endtask

  task automatic test_disable_drain();
    int br, bs, bl, k;
    bit ok;
    apply_reset();
    shf_delay = 3;
    br = runs.size(); bs = starts.size(); bl = lats.size();
    enable = 1'b1;
    k = 0;
    while (!(run_len >= 10 && run_bit == 3) && k < 1500) begin tick(); k++; end
    n_chk++;
    if (!(run_len >= 10 && run_bit == 3)) begin
      n_fail++; $display("FAIL drain_timeout: got bit %0d len %0d want bit 3 in progress", run_bit, run_len);
      enable = 1'b0;
      return;
    end
    enable = 1'b0;
    repeat (200) tick();
    n_chk++; if (runs.size() - br != 4) begin n_fail++; $display("FAIL drain_runs: got %0d want 4", runs.size() - br); end
    n_chk++;
    if (runs[br+3].len != (BASE << 3)) begin n_fail++; $display("FAIL drain_bit3_len: got %0d want %0d", runs[br+3].len, BASE << 3); end
    n_chk++; if (lats.size() - bl != 4) begin n_fail++; $display("FAIL drain_latches: got %0d want 4", lats.size() - bl); end
    n_chk++; if (starts.size() - bs != 5) begin n_fail++; $display("FAIL drain_starts: got %0d want 5", starts.size() - bs); end
    enable = 1'b1;
    wait_runs(br + 5, 500, ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL restart_timeout: got %0d runs want 5", runs.size() - br);
    end else begin
      n_chk++;
      if (starts[bs+5].row != 0 || starts[bs+5].bitp != 0) begin
        n_fail++; $display("FAIL restart_shift: got %0d/%0d want 0/0", starts[bs+5].row, starts[bs+5].bitp);
      end
      n_chk++;
      if (runs[br+4].row != 0 || runs[br+4].bitp != 0 || runs[br+4].len != BASE) begin
        n_fail++; $display("FAIL restart_run: got row %0d bit %0d len %0d want 0 0 %0d",
          runs[br+4].row, runs[br+4].bitp, runs[br+4].len, BASE);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bl, bs, bd, k;
    apply_reset();
    shf_delay = 30;
    enable = 1'b1;
    k = 0;
    while (!(run_len == 5 && run_bit == 2) && k < 1500) begin tick(); k++; end
    n_chk++;
    if (!(run_len == 5 && run_bit == 2)) begin
      n_fail++; $display("FAIL midreset_timeout: got bit %0d len %0d want bit 2 len 5", run_bit, run_len);
      enable = 1'b0;
      return;
    end
    bl = lats.size(); bs = starts.size(); bd = dones.size();
    keep_inflight = 1'b1; reset = 1'b1; enable = 1'b0;
    tick();
    n_chk++; if (oe_n !== 1'b1) begin n_fail++; $display("FAIL midreset_oe_n: got %b want 1", oe_n); end
    reset = 1'b0;
    repeat (60) tick();
    n_chk++; if (dones.size() - bd != 1) begin n_fail++; $display("FAIL midreset_spurious_done: got %0d want 1", dones.size() - bd); end
    n_chk++; if (lats.size() != bl) begin n_fail++; $display("FAIL midreset_no_latch: got %0d latches want 0", lats.size() - bl); end
    n_chk++; if (starts.size() != bs) begin n_fail++; $display("FAIL midreset_no_start: got %0d starts want 0", starts.size() - bs); end
    n_chk++; if (oe_n !== 1'b1) begin n_fail++; $display("FAIL midreset_dark: got %b want 1", oe_n); end
    keep_inflight = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bitplane_order();
    test_slow_shifter();
    test_small_wrap();
    test_disable_drain();
    test_reset_mid();
    n_chk++; if (overlap_err != 0) begin n_fail++; $display("FAIL latch_while_lit: got %0d want 0", overlap_err); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached want completion");
    $fatal(1, "watchdog");
  end
endmodule
